// File: rtl/seq_controller_if.sv
// Instruction fetch handshake between the instruction memory (master) and the sequencer (slave).
interface seq_controller_if #(
    parameter int IW = 8
);
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer: fetch, settle wait, one-cycle execute strobe burst, terminal halt.
// Optional feature: define SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal_op.
//
// state    | meaning
// S_FETCH  | instr_ready high, waiting for a handshake
// S_SETTLE | down-counter running before execute
// S_EXEC   | single cycle carrying the decoded strobes
// S_HALT   | terminal; left only through reset
module seq_controller #(
    parameter int OPC_W         = 4,
    parameter int OPD_W         = 4,
    parameter int ALU_SEL_W     = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    seq_controller_if.slave      fetch_if,
    input  logic                 zero_i,
    input  logic                 carry_i,
    output logic                 load_ir_o,
    output logic                 inc_pc_o,
    output logic                 sel_pc_o,
    output logic                 load_pc_o,
    output logic                 load_reg_o,
    output logic                 dump_reg_o,
    output logic                 load_acc_o,
    output logic                 dump_acc_o,
    output logic [1:0]           sel_acc_o,
    output logic [ALU_SEL_W-1:0] sel_alu_o,
    output logic [OPD_W-1:0]     imm_data_o,
    output logic [OPD_W-1:0]     reg_num_o,
    output logic                 halted_o,
    output logic                 illegal_op_o
);
    localparam int IW = OPC_W + OPD_W;
    localparam logic [7:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {S_FETCH, S_SETTLE, S_EXEC, S_HALT} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [IW-1:0]        ir_q, ir_d;
    logic                 instr_ready_q, instr_ready_d;
    logic                 load_ir_q, load_ir_d, inc_pc_q, inc_pc_d, sel_pc_q, sel_pc_d;
    logic                 load_pc_q, load_pc_d, load_reg_q, load_reg_d, dump_reg_q, dump_reg_d;
    logic                 load_acc_q, load_acc_d, dump_acc_q, dump_acc_d;
    logic [1:0]           sel_acc_q, sel_acc_d;
    logic [ALU_SEL_W-1:0] sel_alu_q, sel_alu_d;
    logic [OPD_W-1:0]     imm_data_q, imm_data_d, reg_num_q, reg_num_d;
    logic                 halted_q, halted_d, illegal_op_q, illegal_op_d;
    logic [IW-1:0]        dec_word;
    logic [OPC_W-1:0]     opcode;
    logic [OPD_W-1:0]     operand;
    logic                 is_illegal;

    // With a zero settle interval the word is decoded straight off the bus on the capture edge.
    assign dec_word   = (state_q == S_FETCH) ? fetch_if.instr : ir_q;
    assign opcode     = dec_word[IW-1:OPD_W];
    assign operand    = dec_word[OPD_W-1:0];
    assign is_illegal = (opcode == OPC_W'(4'b1001)) || (opcode == OPC_W'(4'b1110));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ir_d          = ir_q;
        instr_ready_d = 1'b0;
        load_ir_d     = 1'b0;
        inc_pc_d      = 1'b0;
        load_pc_d     = 1'b0;
        load_reg_d    = 1'b0;
        dump_reg_d    = 1'b0;
        load_acc_d    = 1'b0;
        dump_acc_d    = 1'b0;
        halted_d      = 1'b0;
        illegal_op_d  = 1'b0;
        sel_pc_d      = sel_pc_q;
        sel_acc_d     = sel_acc_q;
        sel_alu_d     = sel_alu_q;
        imm_data_d    = imm_data_q;
        reg_num_d     = reg_num_q;

        case (state_q)
            S_FETCH: begin
                if (instr_ready_q && fetch_if.instr_valid) begin
                    ir_d      = fetch_if.instr;
                    load_ir_d = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) state_d = S_EXEC;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (opcode == OPC_W'(4'b1111)) state_d = S_HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                if (is_illegal) begin
                    state_d      = S_HALT;
                    illegal_op_d = 1'b1;
                end
`endif
            end
            S_HALT:  illegal_op_d = illegal_op_q;
            default: state_d = S_FETCH;
        endcase

        instr_ready_d = (state_d == S_FETCH);
        halted_d      = (state_d == S_HALT);

        // Strobes and operand fields are computed on the edge entering EXEC, so flags are sampled there.
        if (state_d == S_EXEC) begin
            sel_pc_d   = 1'b0;
            sel_acc_d  = 2'b00;
            sel_alu_d  = '0;
            imm_data_d = '0;
            reg_num_d  = '0;
            case (opcode)
                OPC_W'(4'b0000): inc_pc_d = 1'b1;
                OPC_W'(4'b0001), OPC_W'(4'b0010), OPC_W'(4'b0011): begin
                    dump_reg_d = 1'b1;
                    reg_num_d  = operand;
                    sel_acc_d  = 2'b10;
                    load_acc_d = 1'b1;
                    inc_pc_d   = 1'b1;
                    sel_alu_d  = (opcode == OPC_W'(4'b0001)) ? ALU_SEL_W'(4'b0000) :
                                 (opcode == OPC_W'(4'b0010)) ? ALU_SEL_W'(4'b0001) : ALU_SEL_W'(4'b1000);
                end
                OPC_W'(4'b1100), OPC_W'(4'b1011): begin
                    sel_acc_d  = 2'b10;
                    load_acc_d = 1'b1;
                    inc_pc_d   = 1'b1;
                    sel_alu_d  = (opcode == OPC_W'(4'b1100)) ? ALU_SEL_W'(4'b1100) : ALU_SEL_W'(4'b1101);
                end
                OPC_W'(4'b0100): begin
                    dump_reg_d = 1'b1;
                    reg_num_d  = operand;
                    sel_acc_d  = 2'b01;
                    load_acc_d = 1'b1;
                    inc_pc_d   = 1'b1;
                end
                OPC_W'(4'b0101): begin
                    dump_acc_d = 1'b1;
                    load_reg_d = 1'b1;
                    reg_num_d  = operand;
                    inc_pc_d   = 1'b1;
                end
                OPC_W'(4'b1101): begin
                    imm_data_d = operand;
                    sel_acc_d  = 2'b00;
                    load_acc_d = 1'b1;
                    inc_pc_d   = 1'b1;
                end
                OPC_W'(4'b0110), OPC_W'(4'b1000): begin
                    if ((opcode == OPC_W'(4'b0110)) ? zero_i : carry_i) begin
                        load_pc_d = 1'b1;
                        sel_pc_d  = 1'b0;
                        reg_num_d = operand;
                    end else begin
                        inc_pc_d  = 1'b1;
                    end
                end
                OPC_W'(4'b0111), OPC_W'(4'b1010): begin
                    if ((opcode == OPC_W'(4'b0111)) ? zero_i : carry_i) begin
                        load_pc_d  = 1'b1;
                        sel_pc_d   = 1'b1;
                        imm_data_d = operand;
                    end else begin
                        inc_pc_d   = 1'b1;
                    end
                end
                OPC_W'(4'b1111): ;
                default: begin
                    illegal_op_d = is_illegal;
`ifndef SEQ_ILLEGAL_TRAP_EN
                    inc_pc_d     = 1'b1;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_FETCH;
            cnt_q         <= 8'd0;
            ir_q          <= '0;
            instr_ready_q <= 1'b0;
            load_ir_q     <= 1'b0;
            inc_pc_q      <= 1'b0;
            sel_pc_q      <= 1'b0;
            load_pc_q     <= 1'b0;
            load_reg_q    <= 1'b0;
            dump_reg_q    <= 1'b0;
            load_acc_q    <= 1'b0;
            dump_acc_q    <= 1'b0;
            sel_acc_q     <= 2'b00;
            sel_alu_q     <= '0;
            imm_data_q    <= '0;
            reg_num_q     <= '0;
            halted_q      <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ir_q          <= ir_d;
            instr_ready_q <= instr_ready_d;
            load_ir_q     <= load_ir_d;
            inc_pc_q      <= inc_pc_d;
            sel_pc_q      <= sel_pc_d;
            load_pc_q     <= load_pc_d;
            load_reg_q    <= load_reg_d;
            dump_reg_q    <= dump_reg_d;
            load_acc_q    <= load_acc_d;
            dump_acc_q    <= dump_acc_d;
            sel_acc_q     <= sel_acc_d;
            sel_alu_q     <= sel_alu_d;
            imm_data_q    <= imm_data_d;
            reg_num_q     <= reg_num_d;
            halted_q      <= halted_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign fetch_if.instr_ready = instr_ready_q;
    assign load_ir_o    = load_ir_q;
    assign inc_pc_o     = inc_pc_q;
    assign sel_pc_o     = sel_pc_q;
    assign load_pc_o    = load_pc_q;
    assign load_reg_o   = load_reg_q;
    assign dump_reg_o   = dump_reg_q;
    assign load_acc_o   = load_acc_q;
    assign dump_acc_o   = dump_acc_q;
    assign sel_acc_o    = sel_acc_q;
    assign sel_alu_o    = sel_alu_q;
    assign imm_data_o   = imm_data_q;
    assign reg_num_o    = reg_num_q;
    assign halted_o     = halted_q;
    assign illegal_op_o = illegal_op_q;
endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: expected EXEC results are queued at issue and popped at the EXEC cycle.
module tb_seq_controller;
    localparam int SETTLE = 4;
    localparam logic [5:0] INC  = 6'b100000;
    localparam logic [5:0] LPC  = 6'b010000;
    localparam logic [5:0] LREG = 6'b001000;
    localparam logic [5:0] DREG = 6'b000100;
    localparam logic [5:0] LACC = 6'b000010;
    localparam logic [5:0] DACC = 6'b000001;

    typedef struct packed {
        logic [5:0] strb;
        logic [1:0] acc;  logic acc_v;
        logic [3:0] alu;  logic alu_v;
        logic [3:0] imm;  logic imm_v;
        logic [3:0] rn;   logic rn_v;
        logic       pc;   logic pc_v;
        logic       ill;
        logic       halt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       zero = 1'b0, carry = 1'b0;
    logic       load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu, imm_data, reg_num;
    logic       halted, illegal_op;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    seq_controller_if #(.IW(8)) fetch_if ();

    seq_controller #(
        .OPC_W(4), .OPD_W(4), .ALU_SEL_W(4), .SETTLE_CYCLES(SETTLE)
    ) u_dut (
        .clk_i(clk), .reset_i(reset), .fetch_if(fetch_if),
        .zero_i(zero), .carry_i(carry),
        .load_ir_o(load_ir), .inc_pc_o(inc_pc), .sel_pc_o(sel_pc), .load_pc_o(load_pc),
        .load_reg_o(load_reg), .dump_reg_o(dump_reg), .load_acc_o(load_acc), .dump_acc_o(dump_acc),
        .sel_acc_o(sel_acc), .sel_alu_o(sel_alu), .imm_data_o(imm_data), .reg_num_o(reg_num),
        .halted_o(halted), .illegal_op_o(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {inc_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc};
    endfunction

    function automatic logic [31:0] outs();
        return 32'({fetch_if.instr_ready, load_ir, strobes(), sel_pc, sel_acc, sel_alu,
                    imm_data, reg_num, halted, illegal_op});
    endfunction

    function automatic exp_t model(input logic [7:0] w, input logic z, input logic c);
        exp_t e;
        logic [3:0] op, od;
        e  = '0;
        op = w[7:4];
        od = w[3:0];
        case (op)
            4'h0: e.strb = INC;
            4'h1, 4'h2, 4'h3: begin
                e.strb = INC | DREG | LACC;
                e.acc = 2'b10; e.acc_v = 1'b1;
                e.rn  = od;    e.rn_v  = 1'b1;
                e.alu = (op == 4'h1) ? 4'b0000 : (op == 4'h2) ? 4'b0001 : 4'b1000;
                e.alu_v = 1'b1;
            end
            4'hC, 4'hB: begin
                e.strb = INC | LACC;
                e.acc = 2'b10; e.acc_v = 1'b1;
                e.alu = (op == 4'hC) ? 4'b1100 : 4'b1101; e.alu_v = 1'b1;
            end
            4'h4: begin
                e.strb = INC | DREG | LACC;
                e.acc = 2'b01; e.acc_v = 1'b1;
                e.rn  = od;    e.rn_v  = 1'b1;
            end
            4'h5: begin
                e.strb = INC | DACC | LREG;
                e.rn = od; e.rn_v = 1'b1;
            end
            4'hD: begin
                e.strb = INC | LACC;
                e.acc = 2'b00; e.acc_v = 1'b1;
                e.imm = od;    e.imm_v = 1'b1;
            end
            4'h6, 4'h8: begin
                if ((op == 4'h6) ? z : c) begin
                    e.strb = LPC; e.pc = 1'b0; e.pc_v = 1'b1; e.rn = od; e.rn_v = 1'b1;
                end else e.strb = INC;
            end
            4'h7, 4'hA: begin
                if ((op == 4'h7) ? z : c) begin
                    e.strb = LPC; e.pc = 1'b1; e.pc_v = 1'b1; e.imm = od; e.imm_v = 1'b1;
                end else e.strb = INC;
            end
            4'hF: e.halt = 1'b1;
            default: begin
                e.ill = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
                e.halt = 1'b1;
`else
                e.strb = INC;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic do_instr(input logic [7:0] w, input logic z, input logic c);
        exp_t e;
        int   waited = 0;
        exp_q.push_back(model(w, z, c));
        zero  = z;
        carry = c;
        while (!fetch_if.instr_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("ready_wait", 32'(fetch_if.instr_ready), 32'd1);
        fetch_if.instr       = w;
        fetch_if.instr_valid = 1'b1;
        tick();
        check("load_ir", 32'(load_ir), 32'd1);
        fetch_if.instr_valid = 1'b0;
        repeat (SETTLE) tick();
        e = exp_q.pop_front();
        check("load_ir_off", 32'(load_ir), 32'd0);
        check("strobes", 32'(strobes()), 32'(e.strb));
        if (e.acc_v) check("sel_acc", 32'(sel_acc), 32'(e.acc));
        if (e.alu_v) check("sel_alu", 32'(sel_alu), 32'(e.alu));
        if (e.imm_v) check("imm_data", 32'(imm_data), 32'(e.imm));
        if (e.rn_v)  check("reg_num", 32'(reg_num), 32'(e.rn));
        if (e.pc_v)  check("sel_pc", 32'(sel_pc), 32'(e.pc));
        check("illegal_exec", 32'(illegal_op), 32'(e.ill));
        tick();
        check("strobes_off", 32'(strobes()), 32'd0);
        check("halted", 32'(halted), 32'(e.halt));
        check("ready_next", 32'(fetch_if.instr_ready), 32'(!e.halt));
        check("illegal_after", 32'(illegal_op), 32'(e.ill & e.halt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("reset_outs", outs(), 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(fetch_if.instr_ready), 32'd1);
    endtask

    initial begin
        exp_t ei;
        int   bad;
        logic seen;
        fetch_if.instr_valid = 1'b0;
        fetch_if.instr       = 8'h00;
        do_reset();

        do_instr(8'hD7, 1'b0, 1'b0);
        do_instr(8'h13, 1'b0, 1'b0);
        do_instr(8'h2A, 1'b0, 1'b0);
        do_instr(8'h3B, 1'b0, 1'b0);
        do_instr(8'hC0, 1'b0, 1'b0);
        do_instr(8'hB0, 1'b0, 1'b0);
        do_instr(8'h45, 1'b0, 1'b0);
        do_instr(8'h52, 1'b0, 1'b0);
        do_instr(8'h75, 1'b1, 1'b0);
        do_instr(8'h75, 1'b0, 1'b1);
        do_instr(8'h69, 1'b1, 1'b0);
        do_instr(8'h69, 1'b0, 1'b1);
        do_instr(8'h8C, 1'b0, 1'b1);
        do_instr(8'h8C, 1'b1, 1'b0);
        do_instr(8'hAE, 1'b0, 1'b1);
        do_instr(8'hAE, 1'b1, 1'b0);
        do_instr(8'h00, 1'b0, 1'b0);

        // Illegal opcode: trapped (sticky) or executed as NOP depending on the build.
        ei = model(8'h90, 1'b0, 1'b0);
        do_instr(8'h90, 1'b0, 1'b0);
        repeat (5) tick();
        check("illegal_hold", 32'({halted, illegal_op}), 32'({ei.halt, ei.halt}));
        do_reset();
        do_instr(8'hE1, 1'b0, 1'b0);
        do_reset();

        // Reset while STR is settling must abort it without any store strobes.
        fetch_if.instr       = 8'h52;
        fetch_if.instr_valid = 1'b1;
        tick();
        fetch_if.instr_valid = 1'b0;
        check("abort_load_ir", 32'(load_ir), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset_mid_outs", outs(), 32'd0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | load_reg | dump_acc;
        end
        check("abort_no_store", 32'(seen), 32'd0);
        check("abort_ready", 32'(fetch_if.instr_ready), 32'd1);

        // HALT ignores a held instr_valid until reset.
        do_instr(8'hF0, 1'b0, 1'b0);
        fetch_if.instr       = 8'h11;
        fetch_if.instr_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (!halted || fetch_if.instr_ready || load_ir || strobes() != 6'd0) bad++;
        end
        check("halt_hold", 32'(bad), 32'd0);
        fetch_if.instr_valid = 1'b0;
        do_reset();
        do_instr(8'hD3, 1'b0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
